// File: rtl/fp16_div_seq_if.sv
// rtl/fp16_div_seq_if.sv - operand/result handshake bundle for the fp16 sequential divider
interface fp16_div_seq_if;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q;
  logic        out_valid;
  logic        out_ready;
  logic        sNaN_o;
  logic        qNaN_o;
  logic        infinity_o;
  logic        zero_o;
  logic        subnormal_o;
  logic        normal_o;
  logic        div_by_zero_o;

  modport master (
    output op_a, op_b, in_valid, out_ready,
    input  in_ready, q, out_valid,
    input  sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o, div_by_zero_o
  );

  modport slave (
    input  op_a, op_b, in_valid, out_ready,
    output in_ready, q, out_valid,
    output sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o, div_by_zero_o
  );
endinterface

// File: rtl/fp16_div_seq.sv
// rtl/fp16_div_seq.sv - iterative binary16 restoring divider, one quotient bit per cycle
module fp16_div_seq #(
  parameter int          QBITS     = 12,
  parameter logic [15:0] CANON_NAN = 16'h7E00
) (
  input logic           clk,
  input logic           rst_n,
  fp16_div_seq_if.slave bus
);
  // flag vector order: {sNaN, qNaN, inf, zero, subnormal, normal, div_by_zero}
  localparam logic [6:0] F_SNAN = 7'b1000000;
  localparam logic [6:0] F_QNAN = 7'b0100000;
  localparam logic [6:0] F_INF  = 7'b0010000;
  localparam logic [6:0] F_ZERO = 7'b0001000;
  localparam logic [6:0] F_SUB  = 7'b0000100;
  localparam logic [6:0] F_NORM = 7'b0000010;
  localparam logic [6:0] F_DBZ  = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t             state, state_nxt;
  logic               accept;
  logic               sign;
  logic signed [6:0]  exp_a, exp_b;
  logic [10:0]        sig_b;
  logic [11:0]        rem;
  logic [11:0]        qb;
  logic [3:0]         cnt;
  logic [15:0]        res_q, q_r;
  logic [6:0]         res_flags, flags_r;
  logic               ov_r;

  // operand classification at the accept boundary; subnormals count as zero
  logic [4:0] ea, eb;
  logic [9:0] ma, mb;
  logic       a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  assign ea     = bus.op_a[14:10];
  assign eb     = bus.op_b[14:10];
  assign ma     = bus.op_a[9:0];
  assign mb     = bus.op_b[9:0];
  assign a_nan  = (ea == 5'h1F) && (ma != 10'd0);
  assign b_nan  = (eb == 5'h1F) && (mb != 10'd0);
  assign a_snan = a_nan && !ma[9];
  assign b_snan = b_nan && !mb[9];
  assign a_inf  = (ea == 5'h1F) && (ma == 10'd0);
  assign b_inf  = (eb == 5'h1F) && (mb == 10'd0);
  assign a_zero = (ea == 5'd0);
  assign b_zero = (eb == 5'd0);

  logic        sp_hit, in_sign;
  logic [15:0] sp_q;
  logic [6:0]  sp_flags;
  assign in_sign = bus.op_a[15] ^ bus.op_b[15];

  // special-operand result, resolved in priority order
  always_comb begin
    sp_hit   = 1'b1;
    sp_q     = 16'h0000;
    sp_flags = 7'd0;
    if (a_snan) begin
      sp_q = bus.op_a; sp_flags = F_SNAN;
    end else if (b_snan) begin
      sp_q = bus.op_b; sp_flags = F_SNAN;
    end else if (a_nan) begin
      sp_q = bus.op_a; sp_flags = F_QNAN;
    end else if (b_nan) begin
      sp_q = bus.op_b; sp_flags = F_QNAN;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      sp_q = {in_sign | CANON_NAN[15], CANON_NAN[14:0]}; sp_flags = F_QNAN;
    end else if (a_inf) begin
      sp_q = {in_sign, 15'h7C00}; sp_flags = F_INF;
    end else if (b_inf) begin
      sp_q = {in_sign, 15'h0000}; sp_flags = F_ZERO;
    end else if (b_zero) begin
      sp_q = {in_sign, 15'h7C00}; sp_flags = F_INF | F_DBZ;
    end else if (a_zero) begin
      sp_q = {in_sign, 15'h0000}; sp_flags = F_ZERO;
    end else begin
      sp_hit = 1'b0;
    end
  end

  logic signed [6:0] te, e_n, sh_amt;
  logic [10:0]       sig_n;
  logic [9:0]        sub_frac;
  logic [15:0]       norm_q;
  logic [6:0]        norm_flags;

  // normalise the raw quotient and pack it as normal, subnormal, zero or overflow
  always_comb begin
    te = exp_a - exp_b;
    if (qb[11]) begin
      sig_n = qb[11:1];
      e_n   = te;
    end else begin
      sig_n = qb[10:0];
      e_n   = te - 7'sd1;
    end
    sh_amt     = -7'sd14 - e_n;
    sub_frac   = 10'(sig_n >> sh_amt);
    norm_q     = {sign, 15'h0000};
    norm_flags = F_ZERO;
    if (e_n > 7'sd15) begin
      norm_q     = {sign, 15'h7C00};
      norm_flags = F_INF;
    end else if (e_n < -7'sd24) begin
      norm_flags = F_ZERO;
    end else if (e_n < -7'sd14) begin
      if (sub_frac != 10'd0) begin
        norm_q     = {sign, 5'd0, sub_frac};
        norm_flags = F_SUB;
      end
    end else begin
      norm_q     = {sign, 5'(e_n + 7'sd15), sig_n[9:0]};
      norm_flags = F_NORM;
    end
  end

  // handshake outputs derived from the current state
  always_comb begin
    bus.in_ready = rst_n && (state == S_IDLE);
    accept       = bus.in_valid && bus.in_ready;
  end

  // next-state selection
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = sp_hit ? S_DONE : S_DIVIDE;
      S_DIVIDE: if (cnt == 4'(QBITS - 1)) state_nxt = S_NORM;
      S_NORM:   state_nxt = S_DONE;
      S_DONE:   if (ov_r && bus.out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  logic        ge;
  logic [10:0] diff;
  assign ge   = rem >= {1'b0, sig_b};
  assign diff = 11'(rem - {1'b0, sig_b});

  // datapath: operand capture, restoring iterations, result staging and output hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign      <= 1'b0;
      exp_a     <= '0;
      exp_b     <= '0;
      sig_b     <= '0;
      rem       <= '0;
      qb        <= '0;
      cnt       <= '0;
      res_q     <= '0;
      res_flags <= '0;
      q_r       <= '0;
      flags_r   <= '0;
      ov_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          sign      <= in_sign;
          exp_a     <= 7'({2'b00, ea}) - 7'sd15;
          exp_b     <= 7'({2'b00, eb}) - 7'sd15;
          sig_b     <= {1'b1, mb};
          rem       <= {1'b0, 1'b1, ma};
          qb        <= '0;
          cnt       <= '0;
          res_q     <= sp_q;
          res_flags <= sp_flags;
        end
        S_DIVIDE: begin
          rem <= ge ? {diff, 1'b0} : {rem[10:0], 1'b0};
          qb  <= {qb[10:0], ge};
          cnt <= cnt + 4'd1;
        end
        S_NORM: begin
          res_q     <= norm_q;
          res_flags <= norm_flags;
        end
        S_DONE: begin
          if (!ov_r) begin
            ov_r    <= 1'b1;
            q_r     <= res_q;
            flags_r <= res_flags;
          end else if (bus.out_ready) begin
            ov_r    <= 1'b0;
            flags_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.q             = q_r;
  assign bus.out_valid     = ov_r;
  assign bus.sNaN_o        = flags_r[6];
  assign bus.qNaN_o        = flags_r[5];
  assign bus.infinity_o    = flags_r[4];
  assign bus.zero_o        = flags_r[3];
  assign bus.subnormal_o   = flags_r[2];
  assign bus.normal_o      = flags_r[1];
  assign bus.div_by_zero_o = flags_r[0];
endmodule

// File: tb/tb_fp16_div_seq.sv
// tb/tb_fp16_div_seq.sv - randomized and directed self-checking bench for fp16_div_seq
module tb_fp16_div_seq;
  localparam logic [6:0] F_SNAN = 7'b1000000;
  localparam logic [6:0] F_QNAN = 7'b0100000;
  localparam logic [6:0] F_INF  = 7'b0010000;
  localparam logic [6:0] F_ZERO = 7'b0001000;
  localparam logic [6:0] F_SUB  = 7'b0000100;
  localparam logic [6:0] F_NORM = 7'b0000010;
  localparam logic [6:0] F_DBZ  = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  fp16_div_seq_if bus();
  fp16_div_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] flags_now();
    return {bus.sNaN_o, bus.qNaN_o, bus.infinity_o, bus.zero_o,
            bus.subnormal_o, bus.normal_o, bus.div_by_zero_o};
  endfunction

  // value-level reference: exact integer quotient truncated to the binary16 grid
  function automatic logic [22:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic       s;
    logic [4:0] ea, eb;
    logic [9:0] ma, mb;
    bit         an, bn, ai, bi, az, bz;
    longint     sa, sb, nq, m, sub;
    int         d, e;
    s  = a[15] ^ b[15];
    ea = a[14:10]; eb = b[14:10];
    ma = a[9:0];   mb = b[9:0];
    an = (ea == 31) && (ma != 0); bn = (eb == 31) && (mb != 0);
    ai = (ea == 31) && (ma == 0); bi = (eb == 31) && (mb == 0);
    az = (ea == 0);               bz = (eb == 0);
    if (an && !ma[9]) return {F_SNAN, a};
    if (bn && !mb[9]) return {F_SNAN, b};
    if (an) return {F_QNAN, a};
    if (bn) return {F_QNAN, b};
    if ((ai && bi) || (az && bz)) return {F_QNAN, s, 15'h7E00};
    if (ai) return {F_INF, s, 15'h7C00};
    if (bi) return {F_ZERO, s, 15'h0000};
    if (bz) return {F_INF | F_DBZ, s, 15'h7C00};
    if (az) return {F_ZERO, s, 15'h0000};
    sa = 1024 + longint'(ma);
    sb = 1024 + longint'(mb);
    d  = int'(ea) - int'(eb);
    nq = (sa << 20) / sb;
    if (nq >= (longint'(1) << 20)) begin e = d;     m = nq >> 10; end
    else                           begin e = d - 1; m = nq >> 9;  end
    if (e > 15) return {F_INF, s, 15'h7C00};
    if (e >= -14) return {F_NORM, s, 5'(e + 15), 10'(m - 1024)};
    if (d + 24 >= 0) sub = (sa << (d + 24)) / sb;
    else             sub = 0;
    if (sub == 0) return {F_ZERO, s, 15'h0000};
    return {F_SUB, s, 5'd0, 10'(sub)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 3) != 0) v[14:10] = 5'($urandom_range(1, 30));
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 40) begin @(negedge clk); n++; end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input int hold, input logic [22:0] exp);
    int    n;
    int    exp_lat;
    bit    special;
    special = (a[14:10] == 0) || (a[14:10] == 31) || (b[14:10] == 0) || (b[14:10] == 31);
    exp_lat = special ? 1 : 14;
    wait_ready();
    bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", 32'(n), 32'(exp_lat));
    check("q", 32'(bus.q), 32'(exp[15:0]));
    check("flags", 32'(flags_now()), 32'(exp[22:16]));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_q", 32'(bus.q), 32'(exp[15:0]));
      check("hold_flags", {24'd0, bus.out_valid, flags_now()}, {24'd0, 1'b1, exp[22:16]});
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("released", {24'd0, bus.out_valid, flags_now()}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    bus.op_a = '0; bus.op_b = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("reset_q", 32'(bus.q), 32'd0);
    check("reset_valid_flags", {24'd0, bus.out_valid, flags_now()}, 32'd0);
    check("reset_in_ready_rel", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    run_op(16'h4200, 16'h4000, 5, {F_NORM, 16'h3E00});
    run_op(16'h3C00, 16'h4200, 0, {F_NORM, 16'h3555});
    run_op(16'h0400, 16'h4000, 1, {F_SUB, 16'h0200});
    run_op(16'h7BFF, 16'h3800, 0, {F_INF, 16'h7C00});
    run_op(16'h3C00, 16'h0000, 2, {F_INF | F_DBZ, 16'h7C00});
    run_op(16'h0000, 16'h0000, 0, {F_QNAN, 16'h7E00});
    run_op(16'h7C01, 16'h3C00, 0, {F_SNAN, 16'h7C01});
    run_op(16'h7E00, 16'h7D00, 0, {F_SNAN, 16'h7D00});
    run_op(16'hC200, 16'h4000, 0, {F_NORM, 16'hBE00});
    run_op(16'h7C00, 16'hC000, 0, {F_INF, 16'hFC00});
    run_op(16'h3C00, 16'h7C00, 0, {F_ZERO, 16'h0000});

    // abandon an operation mid-divide with a one-cycle reset
    wait_ready();
    bus.op_a = 16'h4200; bus.op_b = 16'h3C00; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_q", 32'(bus.q), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("midrst_no_result", 32'(bus.out_valid), 32'd0);
    run_op(16'h4500, 16'h4000, 0, {F_NORM, 16'h4100});

    for (int i = 0; i < 150; i++) begin
      a = rand_op();
      b = rand_op();
      run_op(a, b, int'($urandom_range(0, 3)), ref_div(a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
